qsys_sdram_cpu_debug_cmd_sync: RTL
==================================

// Module: qsys_sdram_cpu_debug_cmd_sync
// PURPOSE
//  System-clock side of the Nios II JTAG debug path, generalised. Samples the
//  virtual-JTAG update-DR/update-IR strobes and the shifted data/IR from the TCK
//  domain, synchronises and edge-detects them, and queues each update-DR as a
//  command {ir, dr} in a small FIFO. Issues per-IR-code take_action/take_no_action
//  pulses to the OCI debug logic with a valid/ready handshake; drops commands on overflow.
// PARAMETERS
//  IR_W        2   virtual-JTAG IR width; 2**IR_W command channels
//  DR_W        38  shift register / jdo width
//  ACT_BIT     34  jdo bit selecting take_action (1) vs take_no_action (0)
//  SYNC_STAGES 2   synchroniser depth for vs_udr/vs_uir (>=2)
//  FIFO_DEPTH  4   command queue entries (power of 2, >=2)
// PORTS
//  clk             in   1          system clock
//  reset           in   1          synchronous, active-high reset
//  vs_udr          in   1          update-DR level from TCK domain (asynchronous)
//  vs_uir          in   1          update-IR level from TCK domain (asynchronous)
//  ir_in           in   IR_W       IR value; stable >=SYNC_STAGES+2 clk around vs_udr high
//  sr              in   DR_W       shifted DR; same stability rule as ir_in
//  cmd_ready       in   1          consumer accepts head command this cycle
//  clr_overflow    in   1          clears overflow sticky
//  cmd_valid       out  1          FIFO non-empty; head on jdo/cmd_ir
//  jdo             out  DR_W       head command data
//  cmd_ir          out  IR_W       head command IR code
//  take_action     out  2**IR_W    one-hot pulse: pop with jdo[ACT_BIT]=1, bit = cmd_ir
//  take_no_action  out  2**IR_W    one-hot pulse: pop with jdo[ACT_BIT]=0, bit = cmd_ir
//  ir_upd          out  1          one-cycle pulse per update-IR rising edge
//  overflow        out  1          sticky: a command was dropped (FIFO full)
//  fifo_level      out  $clog2(FIFO_DEPTH)+1  current entry count
// BEHAVIOUR
//  - Reset: all sync flops, edge regs, FIFO pointers/count, overflow -> 0;
//    cmd_valid=0, jdo=0, cmd_ir=0, take_*=0, ir_upd=0, fifo_level=0.
//  - Arm counter: loaded with SYNC_STAGES+1 on reset, decrements to 0; edges are
//    suppressed while nonzero (strobe held high across reset gives no command).
//  - Sync: SYNC_STAGES-flop chain per strobe; prev reg; rise = sync & ~prev & armed.
//  - udr rise: capture {ir_in, sr} (sampled that cycle) into tail. Push accepted if
//    count<FIFO_DEPTH, or count==FIFO_DEPTH and pop in same cycle. Else drop, set overflow.
//  - Latency: vs_udr rising into empty FIFO -> cmd_valid high SYNC_STAGES+2 clk later
//    (sync + edge reg + FIFO write); no fall-through.
//  - Pop = cmd_valid & cmd_ready. cmd_ready while !cmd_valid ignored, no pulse.
//  - take_action[k] = pop & cmd_ir==k & jdo[ACT_BIT]; take_no_action likewise with
//    ~jdo[ACT_BIT]; combinational from registered head, exactly one bit per pop.
//  - Simultaneous push+pop: count unchanged; pointers both advance, wrap mod FIFO_DEPTH.
//  - ir_upd: registered pulse, 1 clk, per uir rise; independent of FIFO state.
//  - overflow: set on drop, cleared by clr_overflow; set wins if same cycle.
//  - jdo/cmd_ir hold head value while cmd_valid & !cmd_ready; retain last value when empty.
//  - Reset mid-operation: queued commands discarded, no take_* pulse in reset cycle.
// TESTING
//  1 Reset release with vs_udr held 1 -> no cmd_valid over 10 clk, fifo_level=0.
//  2 ir_in=2, sr[34]=1, vs_udr 0->1, cmd_ready=1 -> cmd_valid at +4 clk (SYNC=2),
//    take_action=4'b0100 one clk, jdo==sr.
//  3 Five udr pulses, cmd_ready=0, DEPTH=4 -> fifo_level=4, overflow=1, 5th lost;
//    then drain: 4 pops in order, take_* match each ir/sr[34].
//  4 FIFO full + push and pop same cycle -> push accepted, level stays 4, overflow 0.
//  5 clr_overflow coincident with drop -> overflow stays 1; next cycle clr -> 0.
//  6 vs_uir pulse during drain -> ir_upd exactly 1 clk, queue order unaffected;
//    reset asserted with level=3 -> level 0, cmd_valid 0 next clk.

Source files
------------

// File: rtl/qsys_sdram_cpu_debug_cmd_sync.sv
// qsys_sdram_cpu_debug_cmd_sync
//   System-clock side of the JTAG debug command path. The update-DR and update-IR
//   strobes arrive asynchronously from the TCK domain; each is synchronised and
//   edge-detected. Every update-DR rising edge queues a command {ir_in, sr} into a
//   small FIFO. The head is presented on cmd_ir/jdo with a valid/ready handshake.
//   Each pop raises one bit of take_action or take_no_action, chosen by jdo[ACT_BIT].
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   vs_udr, vs_uir   asynchronous update-DR / update-IR levels
//   ir_in, sr        IR code and shifted DR, held stable around vs_udr
//   cmd_ready        consumer accepts the head command
//   clr_overflow     clears the overflow sticky bit
//   cmd_valid        queue non-empty, head on cmd_ir/jdo
//   jdo, cmd_ir      head command (last popped value while empty)
//   take_action      one-hot pop pulse, bit = cmd_ir, when jdo[ACT_BIT]=1
//   take_no_action   one-hot pop pulse, bit = cmd_ir, when jdo[ACT_BIT]=0
//   ir_upd           one-cycle pulse per update-IR rising edge
//   overflow         sticky: a command was dropped because the queue was full
//   fifo_level       current entry count
module qsys_sdram_cpu_debug_cmd_sync #(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned DR_W        = 38,
    parameter int unsigned ACT_BIT     = 34,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic [DR_W-1:0]                 sr,
    input  logic                            cmd_ready,
    input  logic                            clr_overflow,
    output logic                            cmd_valid,
    output logic [DR_W-1:0]                 jdo,
    output logic [IR_W-1:0]                 cmd_ir,
    output logic [(2**IR_W)-1:0]            take_action,
    output logic [(2**IR_W)-1:0]            take_no_action,
    output logic                            ir_upd,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
    localparam int unsigned CMD_W = IR_W + DR_W;

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic                   udr_prev_q, udr_prev_d;
    logic                   uir_prev_q, uir_prev_d;
    logic                   udr_rise_q, udr_rise_d;
    logic                   ir_upd_q,   ir_upd_d;
    logic [ARM_W-1:0]       arm_q,      arm_d;
    logic [CMD_W-1:0]       mem_q [FIFO_DEPTH];
    logic [CMD_W-1:0]       mem_d [FIFO_DEPTH];
    logic [CMD_W-1:0]       last_q,     last_d;
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]       count_q,    count_d;
    logic                   overflow_q, overflow_d;

    logic                   armed;
    logic                   pop;
    logic                   push;
    logic [CMD_W-1:0]       head;

    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_prev_d = udr_sync_q[SYNC_STAGES-1];
        uir_prev_d = uir_sync_q[SYNC_STAGES-1];
        mem_d      = mem_q;
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // Edges are ignored until the synchronisers have flushed after reset,
        // so a strobe held high across reset never looks like a fresh edge.
        armed = (arm_q == '0);
        arm_d = armed ? arm_q : arm_q - ARM_W'(1);

        udr_rise_d = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q & armed;
        ir_upd_d   = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q & armed;

        cmd_valid = (count_q != '0);
        head      = mem_q[rd_ptr_q];
        pop       = cmd_valid & cmd_ready & ~reset;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push      = udr_rise_q & ((count_q < CNT_W'(FIFO_DEPTH)) | pop);

        if (push) begin
            mem_d[wr_ptr_q] = {ir_in, sr};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = head;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (udr_rise_q && !push) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        // While empty, keep showing the most recently popped command.
        {cmd_ir, jdo}  = cmd_valid ? head : last_q;
        take_action    = '0;
        take_no_action = '0;
        if (pop) begin
            if (jdo[ACT_BIT]) begin
                take_action[cmd_ir] = 1'b1;
            end else begin
                take_no_action[cmd_ir] = 1'b1;
            end
        end

        ir_upd     = ir_upd_q;
        overflow   = overflow_q;
        fifo_level = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            udr_prev_q <= 1'b0;
            uir_prev_q <= 1'b0;
            udr_rise_q <= 1'b0;
            ir_upd_q   <= 1'b0;
            arm_q      <= ARM_W'(SYNC_STAGES + 1);
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            udr_sync_q <= udr_sync_d;
            uir_sync_q <= uir_sync_d;
            udr_prev_q <= udr_prev_d;
            uir_prev_q <= uir_prev_d;
            udr_rise_q <= udr_rise_d;
            ir_upd_q   <= ir_upd_d;
            arm_q      <= arm_d;
            mem_q      <= mem_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
